// File: rtl/onchip_mem_pkg.sv
// Shared types and helpers for the pipelined on-chip RAM slave.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package onchip_mem_pkg;

  // Controller states: CLEAR sweeps zeros into the array, RUN serves traffic.
  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  localparam int BYTE_BITS = 8;

  // Number of byte lanes on a data bus of the given width.
  function automatic int lane_count(input int data_width);
    return data_width / BYTE_BITS;
  endfunction

  // Only a bare RAM read (1) or RAM read plus output register (2) exist.
  function automatic bit read_latency_ok(input int read_latency);
    return (read_latency == 1) || (read_latency == 2);
  endfunction

  // Even parity: the stored bit makes the byte plus bit hold an even number of ones.
  function automatic logic byte_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/onchip_mem_ram_core.sv
// Inferred single-port byte-enabled RAM, optional per-lane parity bits stored alongside.
// Latency: 1 cycle, rdata registered on re and held otherwise.
// Backpressure: none; caller guarantees at most one of we/re per cycle.
module onchip_mem_ram_core
  import onchip_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int PAR_BITS   = 0,
  parameter int ADDR_WIDTH = 12,
  parameter int DEPTH      = 4096
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic                           re,
  input  logic [ADDR_WIDTH-1:0]          addr,
  input  logic [DATA_WIDTH/8-1:0]        be,
  input  logic [DATA_WIDTH+PAR_BITS-1:0] wdata,
  output logic [DATA_WIDTH+PAR_BITS-1:0] rdata
);

  localparam int LANES = lane_count(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] q_dat;

  // Data array: per-lane write, registered read.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < LANES; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (re) q_dat <= mem[addr];
  end

  if (PAR_BITS > 0) begin : g_par
    logic [PAR_BITS-1:0] pmem [DEPTH];
    logic [PAR_BITS-1:0] q_par;

    // Parity array follows the same lane enables as the data bytes.
    always_ff @(posedge clk) begin
      if (we) begin
        for (int i = 0; i < PAR_BITS; i++) begin
          if (be[i]) pmem[addr][i] <= wdata[DATA_WIDTH + i];
        end
      end
      if (re) q_par <= pmem[addr];
    end

    assign rdata = {q_par, q_dat};
  end else begin : g_nopar
    assign rdata = q_dat;
  end

endmodule

// File: rtl/onchip_memory_pipelined.sv
// Avalon-MM on-chip RAM slave with post-reset clear sweep; ONCHIP_MEM_PARITY_EN adds byte parity.
// Latency: READ_LATENCY (1 or 2) enabled cycles from read accept to readdatavalid.
// Backpressure: waitrequest during clear sweep or while en is low; pipeline freezes when en is low.
module onchip_memory_pipelined
  import onchip_mem_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 12,
  parameter int DEPTH          = 4096,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    chipselect,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH/8-1:0] byteenable,
  input  logic                    read,
  input  logic                    write,
  input  logic [DATA_WIDTH-1:0]   writedata,
  input  logic                    clken,
  input  logic                    reset_req,
  input  logic                    freeze,
  output logic [DATA_WIDTH-1:0]   readdata,
  output logic                    readdatavalid,
`ifdef ONCHIP_MEM_PARITY_EN
  output logic                    parity_err,
`endif
  output logic                    waitrequest
);

  localparam int LANES = lane_count(DATA_WIDTH);
`ifdef ONCHIP_MEM_PARITY_EN
  localparam int PAR_BITS = LANES;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int W = DATA_WIDTH + PAR_BITS;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  if (!read_latency_ok(READ_LATENCY) || (DEPTH > (1 << ADDR_WIDTH))) begin : g_bad_cfg
    $error("onchip_memory_pipelined: READ_LATENCY must be 1 or 2 and DEPTH <= 2**ADDR_WIDTH");
  end

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   clr_addr;
  logic                    en, clearing, in_range, wr_acc, rd_acc;
  logic                    ram_we, ram_re;
  logic [ADDR_WIDTH-1:0]   ram_addr;
  logic [LANES-1:0]        ram_be;
  logic [W-1:0]            ram_wdata, ram_rdata;
  logic                    v1, oor1;
  logic [DATA_WIDTH-1:0]   s1_dat, out_dat, rd_hold;
  logic                    out_vld;

  assign en          = clken & ~reset_req;
  assign clearing    = (state == CLEAR);
  assign waitrequest = clearing | ~en;
  assign in_range    = ({1'b0, address} < (ADDR_WIDTH + 1)'(DEPTH));
  assign wr_acc      = chipselect & write & ~waitrequest & ~freeze;
  assign rd_acc      = chipselect & read & ~write & ~waitrequest;

  // Single RAM port shared between the clear sweep and bus traffic.
  assign ram_we   = ~reset & ((clearing & en) | (wr_acc & in_range));
  assign ram_re   = ~reset & rd_acc & in_range;
  assign ram_addr = clearing ? clr_addr : address;
  assign ram_be   = clearing ? '1 : byteenable;

`ifdef ONCHIP_MEM_PARITY_EN
  logic [LANES-1:0] wpar, rchk;
  logic             s1_err, out_err;

  // Parity generated on write and re-checked per lane on the RAM output.
  always_comb begin
    wpar = '0;
    rchk = '0;
    for (int i = 0; i < LANES; i++) begin
      wpar[i] = byte_parity(writedata[8*i +: 8]);
      rchk[i] = byte_parity(ram_rdata[8*i +: 8]) ^ ram_rdata[DATA_WIDTH + i];
    end
  end

  assign ram_wdata = clearing ? '0 : {wpar, writedata};
  assign s1_err    = ~oor1 & (|rchk);
`else
  assign ram_wdata = clearing ? '0 : writedata;
`endif

  onchip_mem_ram_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .PAR_BITS   (PAR_BITS),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .be    (ram_be),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Controller: sweep zeros through every word once, then serve traffic; sweep stalls with en.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
      clr_addr <= '0;
    end else if (clearing && en) begin
      if (clr_addr == LAST_ADDR) state <= RUN;
      else                       clr_addr <= clr_addr + 1'b1;
    end
  end

  // Stage 1 tracks the RAM read; out-of-range reads are flagged so they return zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      v1   <= 1'b0;
      oor1 <= 1'b0;
    end else if (en) begin
      v1 <= rd_acc;
      if (rd_acc) oor1 <= ~in_range;
    end
  end

  assign s1_dat = oor1 ? '0 : ram_rdata[DATA_WIDTH-1:0];

  if (READ_LATENCY == 2) begin : g_lat2
    logic                  v2;
    logic [DATA_WIDTH-1:0] d2;

    // Output register stage, advancing only on enabled cycles.
    always_ff @(posedge clk) begin
      if (reset) begin
        v2 <= 1'b0;
        d2 <= '0;
      end else if (en) begin
        v2 <= v1;
        if (v1) d2 <= s1_dat;
      end
    end

    assign out_vld = v2;
    assign out_dat = d2;
  end else begin : g_lat1
    assign out_vld = v1;
    assign out_dat = s1_dat;
  end

`ifdef ONCHIP_MEM_PARITY_EN
  if (READ_LATENCY == 2) begin : g_err2
    logic e2;

    // Parity verdict travels with its data through the output register.
    always_ff @(posedge clk) begin
      if (reset)          e2 <= 1'b0;
      else if (en && v1)  e2 <= s1_err;
    end

    assign out_err = e2;
  end else begin : g_err1
    assign out_err = s1_err;
  end

  assign parity_err = readdatavalid & out_err;
`endif

  // A completed read is only presented on an enabled cycle; readdata otherwise holds the last one.
  assign readdatavalid = out_vld & en;
  assign readdata      = readdatavalid ? out_dat : rd_hold;

  // Remember the last presented word so readdata is stable between valid pulses.
  always_ff @(posedge clk) begin
    if (reset)              rd_hold <= '0;
    else if (readdatavalid) rd_hold <= out_dat;
  end

endmodule
